apb_master_bridge: RTL and testbench

APB requester that turns a simple single-outstanding command/response interface into APB SETUP/ACCESS transfers. It drives the same APB slave port the SPI register block exposes (addr, psel, penable, write, wdata / rdata, ready, slverr). It sits between a test or host sequencer and the peripheral bus. It adds a bounded wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 tb/tb_apb_master_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB requester with a bounded ACCESS wait timeout.
// All outputs are registered except cmd_ready_out, which is decoded from the idle state.
module apb_master_bridge #(
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLE  = 6
) (
   input  logic                      apb_clk_in,
   input  logic                      apb_rst_in,
   input  logic                      cmd_valid_in,
   output logic                      cmd_ready_out,
   input  logic                      cmd_write_in,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
   input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
   output logic                      rsp_valid_out,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
   output logic                      rsp_err_out,
   output logic                      rsp_timeout_out,
   output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
   output logic                      apb_psel_out,
   output logic                      apb_penable_out,
   output logic                      apb_write_out,
   output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
   input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
   input  logic                      apb_ready_in,
   input  logic                      apb_slverr_in
);

   localparam int unsigned CntW = (TIMEOUT_CYCLE < 1) ? 1 : $clog2(TIMEOUT_CYCLE + 1);
   // Counter value at the start of the final permitted ACCESS cycle.
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLE - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                    r_state;
   logic [CntW-1:0]           r_cnt;
   logic                      r_rsp_valid;
   logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
   logic                      r_rsp_err;
   logic                      r_rsp_timeout;
   logic [APB_ADDR_WIDTH-1:0] r_addr;
   logic                      r_psel;
   logic                      r_penable;
   logic                      r_write;
   logic [APB_DATA_WIDTH-1:0] r_wdata;

   always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
      if (apb_rst_in) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_addr        <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_write       <= 1'b0;
         r_wdata       <= '0;
      end else begin
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_penable <= 1'b0;
               if (cmd_valid_in) begin
                  r_addr  <= cmd_addr_in;
                  r_wdata <= cmd_wdata_in;
                  r_write <= cmd_write_in;
                  r_psel  <= 1'b1;
                  r_state <= StSetup;
               end else begin
                  r_psel <= 1'b0;
               end
            end
            StSetup: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= StAccess;
            end
            StAccess: begin
               // Ready takes priority over a timeout firing on the same edge.
               if (apb_ready_in) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= StIdle;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= apb_slverr_in;
                  r_rsp_rdata <= r_write ? '0 : apb_rdata_in;
               end else if (TIMEOUT_CYCLE != 0) begin
                  if (r_cnt == CntLast) begin
                     r_psel        <= 1'b0;
                     r_penable     <= 1'b0;
                     r_state       <= StIdle;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_err     <= 1'b1;
                     r_rsp_timeout <= 1'b1;
                     r_rsp_rdata   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign cmd_ready_out   = (r_state == StIdle);
   assign rsp_valid_out   = r_rsp_valid;
   assign rsp_rdata_out   = r_rsp_rdata;
   assign rsp_err_out     = r_rsp_err;
   assign rsp_timeout_out = r_rsp_timeout;
   assign apb_addr_out    = r_addr;
   assign apb_psel_out    = r_psel;
   assign apb_penable_out = r_penable;
   assign apb_write_out   = r_write;
   assign apb_wdata_out   = r_wdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: checks bus phases, responses, timeout and async reset.
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   apb_master_bridge #(
      .APB_DATA_WIDTH(32),
      .APB_ADDR_WIDTH(32),
      .TIMEOUT_CYCLE (6)
   ) dut (
      .apb_clk_in     (clk),
      .apb_rst_in     (rst),
      .cmd_valid_in   (cmd_valid),
      .cmd_ready_out  (cmd_ready),
      .cmd_write_in   (cmd_write),
      .cmd_addr_in    (cmd_addr),
      .cmd_wdata_in   (cmd_wdata),
      .rsp_valid_out  (rsp_valid),
      .rsp_rdata_out  (rsp_rdata),
      .rsp_err_out    (rsp_err),
      .rsp_timeout_out(rsp_timeout),
      .apb_addr_out   (paddr),
      .apb_psel_out   (psel),
      .apb_penable_out(penable),
      .apb_write_out  (pwrite),
      .apb_wdata_out  (pwdata),
      .apb_rdata_in   (prdata),
      .apb_ready_in   (pready),
      .apb_slverr_in  (pslverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected bus phase: {psel, penable}
   task automatic check_bus(input string tag, input logic s, input logic e);
      check({tag, ".psel"}, {31'd0, psel}, {31'd0, s});
      check({tag, ".penable"}, {31'd0, penable}, {31'd0, e});
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic er, input logic to,
                            input logic [31:0] rd);
      check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
      check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, er});
      check({tag, ".rsp_timeout"}, {31'd0, rsp_timeout}, {31'd0, to});
      check({tag, ".rsp_rdata"}, rsp_rdata, rd);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;

      // Reset
      tick();
      tick();
      check_bus("rst", 1'b0, 1'b0);
      check_rsp("rst", 1'b0, 1'b0, 1'b0, 32'h0);
      check("rst.paddr", paddr, 32'h0);
      rst = 1'b0;
      tick();
      check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_bus("idle", 1'b0, 1'b0);

      // Zero-wait write
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'ha030_0004;
      cmd_wdata = 32'h0000_00c5;
      pready    = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check_bus("wr.setup", 1'b1, 1'b0);
      check("wr.paddr", paddr, 32'ha030_0004);
      check("wr.pwdata", pwdata, 32'h0000_00c5);
      check("wr.pwrite", {31'd0, pwrite}, 32'd1);
      check("wr.cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      check_bus("wr.access", 1'b1, 1'b1);
      check("wr.access.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check_bus("wr.done", 1'b0, 1'b0);
      check_rsp("wr.rsp", 1'b1, 1'b0, 1'b0, 32'h0);
      check("wr.rsp.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      check("wr.pulse_end", {31'd0, rsp_valid}, 32'd0);
      check("wr.addr_hold", paddr, 32'ha030_0004);

      // Read with two wait states
      pready    = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'ha030_0008;
      cmd_wdata = 32'h1111_1111;
      tick();
      cmd_valid = 1'b0;
      check_bus("rd.setup", 1'b1, 1'b0);
      check("rd.pwrite", {31'd0, pwrite}, 32'd0);
      check("rd.paddr", paddr, 32'ha030_0008);
      tick();
      check_bus("rd.access1", 1'b1, 1'b1);
      tick();
      check_bus("rd.access2", 1'b1, 1'b1);
      tick();
      check_bus("rd.access3", 1'b1, 1'b1);
      check("rd.access3.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      pready = 1'b1;
      prdata = 32'h0000_0080;
      tick();
      pready = 1'b0;
      prdata = 32'h0;
      check_bus("rd.done", 1'b0, 1'b0);
      check_rsp("rd.rsp", 1'b1, 1'b0, 1'b0, 32'h0000_0080);
      tick();
      check_rsp("rd.after", 1'b0, 1'b0, 1'b0, 32'h0000_0080);

      // Slave error on a write
      pready    = 1'b1;
      pslverr   = 1'b1;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'ha030_000c;
      cmd_wdata = 32'h0000_0001;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check_rsp("err.rsp", 1'b1, 1'b1, 1'b0, 32'h0);
      pslverr = 1'b0;
      tick();
      check_rsp("err.after", 1'b0, 1'b0, 1'b0, 32'h0);

      // Timeout: ready held low through six ACCESS cycles
      pready    = 1'b0;
      prdata    = 32'hdead_beef;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'ha030_0010;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      check_bus("to.access6", 1'b1, 1'b1);
      check("to.access6.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check_bus("to.abort", 1'b0, 1'b0);
      check_rsp("to.rsp", 1'b1, 1'b1, 1'b1, 32'h0);
      check("to.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      check_rsp("to.after", 1'b0, 1'b0, 1'b0, 32'h0);

      // Ready arrives exactly on the edge the timeout would fire
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      pready = 1'b1;
      prdata = 32'h0000_1234;
      tick();
      pready = 1'b0;
      check_bus("race.done", 1'b0, 1'b0);
      check_rsp("race.rsp", 1'b1, 1'b0, 1'b0, 32'h0000_1234);
      tick();

      // Back-to-back: write then read with cmd_valid held
      pready    = 1'b1;
      prdata    = 32'h0000_0055;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'ha030_0020;
      cmd_wdata = 32'h0000_00aa;
      tick();
      cmd_write = 1'b0;
      cmd_addr  = 32'ha030_0024;
      cmd_wdata = 32'h0;
      check("b2b.wr.pwdata", pwdata, 32'h0000_00aa);
      tick();
      tick();
      check_rsp("b2b.wr.rsp", 1'b1, 1'b0, 1'b0, 32'h0);
      check("b2b.wr.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_bus("b2b.gap", 1'b0, 1'b0);
      tick();
      cmd_valid = 1'b0;
      check_bus("b2b.rd.setup", 1'b1, 1'b0);
      check("b2b.rd.paddr", paddr, 32'ha030_0024);
      check("b2b.rd.pwrite", {31'd0, pwrite}, 32'd0);
      check("b2b.rd.no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      tick();
      check_rsp("b2b.rd.rsp", 1'b1, 1'b0, 1'b0, 32'h0000_0055);
      tick();

      // Async reset in the middle of ACCESS
      pready    = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'ha030_0030;
      tick();
      cmd_valid = 1'b0;
      tick();
      check_bus("ar.access", 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_bus("ar.during", 1'b0, 1'b0);
      check("ar.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("ar.rsp_rdata", rsp_rdata, 32'h0);
      rst = 1'b0;
      tick();
      check("ar.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("ar.no_rsp1", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("ar.no_rsp2", {31'd0, rsp_valid}, 32'd0);
      check_bus("ar.idle", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
